arb_mux_nto1: RTL and testbench

//  Parametrised N-to-1 datapath multiplexer with a valid/ready handshake and one registered output stage.

---
 rtl/arb_mux_pkg.sv | 34 +++
 rtl/arb_mux_nto1_rr_arbiter.sv | 42 ++++
 rtl/arb_mux_nto1.sv | 159 +++++++++++++++
 tb/tb_arb_mux_nto1.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared constants, state encodings and width helpers for the N-to-1 arbitrated mux.
package arb_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    typedef enum logic {
        LOCK_IDLE   = 1'b0,
        LOCK_LOCKED = 1'b1
    } lock_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // A single channel index still needs one bit of select.
    function automatic int sel_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

endpackage

// File: rtl/arb_mux_nto1_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or above the pointer, wrapping.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [SEL_W-1:0]    i_ptr,
    output logic [SEL_W-1:0]    o_gnt,
    output logic                o_gnt_valid
);

    localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

    logic [SEL_W-1:0]    w_idx [CHANNELS];
    logic [CHANNELS-1:0] w_req_rot;

    // One extra bit holds ptr+offset; a single subtract wraps because ptr < CHANNELS.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_rot
            logic [SEL_W:0] w_sum;
            assign w_sum          = {1'b0, i_ptr} + (SEL_W+1)'(gi);
            assign w_idx[gi]      = (w_sum >= CH_W) ? SEL_W'(w_sum - CH_W) : SEL_W'(w_sum);
            assign w_req_rot[gi]  = i_req[w_idx[gi]];
        end
    endgenerate

    // Walk downwards so the smallest rotation offset is the last (winning) assignment.
    always_comb begin
        o_gnt       = '0;
        o_gnt_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                o_gnt       = w_idx[i];
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_nto1.sv
// N-to-1 valid/ready mux with one registered output stage; select or round-robin channel choice.
// Optional packet locking (last_i/last_o) is compiled in when ARB_MUX_LOCK_EN is defined.
module arb_mux_nto1
    import arb_mux_pkg::*;
#(
    parameter  int SIZE     = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 0,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [CHANNELS*SIZE-1:0] data_i,
    input  logic [CHANNELS-1:0]      valid_i,
    output logic [CHANNELS-1:0]      ready_o,
    input  logic [SEL_W-1:0]         select_i,
`ifdef ARB_MUX_LOCK_EN
    input  logic [CHANNELS-1:0]      last_i,
    output logic                     last_o,
`endif
    output logic [SIZE-1:0]          data_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [SEL_W-1:0]         grant_o
);

    localparam logic [SEL_W:0] CH_W = (SEL_W+1)'(CHANNELS);

    out_state_t       r_out_state;
    logic [SIZE-1:0]  r_data;
    logic [SEL_W-1:0] r_grant;
    logic [SEL_W-1:0] r_ptr;

    logic             w_can_accept;
    logic             w_sel_in_range;
    logic [SEL_W-1:0] w_rr_g;
    logic             w_rr_gv;
    logic [SEL_W-1:0] w_base_g;
    logic             w_base_gv;
    logic [SEL_W-1:0] w_g;
    logic             w_gv;
    logic [SIZE-1:0]  w_data_g;
    logic             w_valid_g;
    logic             w_load;
    logic [SEL_W-1:0] w_ptr_next;

`ifdef ARB_MUX_LOCK_EN
    lock_state_t      r_lock_state;
    logic [SEL_W-1:0] r_lock_ch;
    logic             r_last;
    logic             w_last_g;
`endif

    assign w_can_accept   = (r_out_state == OUT_EMPTY) || ready_i;
    assign w_sel_in_range = ({1'b0, select_i} < CH_W);

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .i_req       (valid_i),
        .i_ptr       (r_ptr),
        .o_gnt       (w_rr_g),
        .o_gnt_valid (w_rr_gv)
    );

    always_comb begin
        if (MODE == MODE_RR) begin
            w_base_g  = w_rr_g;
            w_base_gv = w_rr_gv;
        end else begin
            w_base_g  = select_i;
            w_base_gv = w_sel_in_range;
        end
    end

`ifdef ARB_MUX_LOCK_EN
    // An open packet pins the grant to its channel regardless of select_i or the pointer.
    always_comb begin
        w_g  = w_base_g;
        w_gv = w_base_gv;
        if (r_lock_state == LOCK_LOCKED) begin
            w_g  = r_lock_ch;
            w_gv = 1'b1;
        end
    end
`else
    assign w_g  = w_base_g;
    assign w_gv = w_base_gv;
`endif

    always_comb begin
        w_data_g  = '0;
        w_valid_g = 1'b0;
`ifdef ARB_MUX_LOCK_EN
        w_last_g  = 1'b0;
`endif
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_g == SEL_W'(c)) begin
                w_data_g  = data_i[c*SIZE +: SIZE];
                w_valid_g = valid_i[c];
`ifdef ARB_MUX_LOCK_EN
                w_last_g  = last_i[c];
`endif
            end
        end
    end

    assign w_load     = w_can_accept && w_gv && w_valid_g;
    assign w_ptr_next = (w_g == SEL_W'(CHANNELS - 1)) ? '0 : w_g + SEL_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ready
            assign ready_o[gi] = w_load && (w_g == SEL_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_state  <= OUT_EMPTY;
            r_data       <= '0;
            r_grant      <= '0;
            r_ptr        <= '0;
`ifdef ARB_MUX_LOCK_EN
            r_lock_state <= LOCK_IDLE;
            r_lock_ch    <= '0;
            r_last       <= 1'b0;
`endif
        end else begin
            // A load covers both the empty case and drain-plus-refill on the same edge.
            if (w_load) begin
                r_out_state <= OUT_FULL;
                r_data      <= w_data_g;
                r_grant     <= w_g;
                r_ptr       <= w_ptr_next;
`ifdef ARB_MUX_LOCK_EN
                r_last      <= w_last_g;
                if (w_last_g) begin
                    r_lock_state <= LOCK_IDLE;
                end else begin
                    r_lock_state <= LOCK_LOCKED;
                    r_lock_ch    <= w_g;
                end
`endif
            end else if ((r_out_state == OUT_FULL) && ready_i) begin
                r_out_state <= OUT_EMPTY;
            end
        end
    end

    assign data_o  = r_data;
    assign valid_o = (r_out_state == OUT_FULL);
    assign grant_o = r_grant;
`ifdef ARB_MUX_LOCK_EN
    assign last_o  = r_last;
`endif

endmodule

// File: tb/tb_arb_mux_nto1.sv
// Directed bench: one MODE 0 and one MODE 1 instance driven by shared stimulus.
module tb_arb_mux_nto1;

    localparam int SIZE = 32;
    localparam int CH   = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*SIZE-1:0] data;
    logic [CH-1:0]    valid;
    logic [1:0]       sel;
    logic             ready;

    logic [CH-1:0]    s_ready, r_ready;
    logic [SIZE-1:0]  s_data, r_data;
    logic             s_valid, r_valid;
    logic [1:0]       s_grant, r_grant;
`ifdef ARB_MUX_LOCK_EN
    logic [CH-1:0]    last;
    logic             s_last, r_last;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    arb_mux_nto1 #(.SIZE(SIZE), .CHANNELS(CH), .MODE(0)) u_sel (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (data),
        .valid_i  (valid),
        .ready_o  (s_ready),
        .select_i (sel),
`ifdef ARB_MUX_LOCK_EN
        .last_i   (last),
        .last_o   (s_last),
`endif
        .data_o   (s_data),
        .valid_o  (s_valid),
        .ready_i  (ready),
        .grant_o  (s_grant)
    );

    arb_mux_nto1 #(.SIZE(SIZE), .CHANNELS(CH), .MODE(1)) u_rr (
        .clk_i    (clk),
        .rst_i    (rst),
        .data_i   (data),
        .valid_i  (valid),
        .ready_o  (r_ready),
        .select_i (sel),
`ifdef ARB_MUX_LOCK_EN
        .last_i   (last),
        .last_o   (r_last),
`endif
        .data_o   (r_data),
        .valid_o  (r_valid),
        .ready_i  (ready),
        .grant_o  (r_grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [31:0] v);
        data[c*SIZE +: SIZE] = v;
    endtask

    initial begin
        rst   = 1'b1;
        data  = '0;
        valid = '0;
        sel   = 2'd0;
        ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        last  = '1;
`endif
        step();
        step();
        rst = 1'b0;
        chk("reset_s_valid", s_valid, 0);
        chk("reset_s_data", s_data, 0);
        chk("reset_s_grant", s_grant, 0);
        chk("reset_r_valid", r_valid, 0);

        // Reset while holding a beat
        sel = 2'd1; valid = 3'b010; set_ch(1, 32'hDEAD); ready = 1'b0;
        step();
        chk("pre_rst_s_valid", s_valid, 1);
        chk("pre_rst_s_data", s_data, 32'hDEAD);
        chk("pre_rst_s_grant", s_grant, 1);
        valid = 3'b000; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_rst_s_valid", s_valid, 0);
        chk("post_rst_s_data", s_data, 0);
        chk("post_rst_s_grant", s_grant, 0);
        chk("post_rst_r_valid", r_valid, 0);
        ready = 1'b1;
        step();
        chk("no_deliver_s_valid", s_valid, 0);

        // MODE 0 select
        sel = 2'd2; valid = 3'b100; set_ch(2, 32'hA5A5A5A5);
        #1;
        chk("sel2_ready", s_ready, 3'b100);
        step();
        chk("sel2_data", s_data, 32'hA5A5A5A5);
        chk("sel2_grant", s_grant, 2);
        chk("sel2_valid", s_valid, 1);
        sel = 2'd3;
        #1;
        chk("sel3_ready", s_ready, 3'b000);
        step();
        chk("sel3_valid", s_valid, 0);
        chk("sel3_data_hold", s_data, 32'hA5A5A5A5);
        valid = 3'b000;
        step();
        chk("rr_drain_valid", r_valid, 0);

        // MODE 1 continuous round robin
        set_ch(0, 32'h100); set_ch(1, 32'h101); set_ch(2, 32'h102);
        valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_seq_grant", r_grant, k % 3);
            chk("rr_seq_valid", r_valid, 1);
            chk("rr_seq_data", r_data, 32'h100 + (k % 3));
        end
        valid = 3'b000;
        step();
        chk("rr_seq_drain", r_valid, 0);

        // Backpressure
        set_ch(0, 32'h11); valid = 3'b001;
        step();
        chk("bp_fill_data", r_data, 32'h11);
        ready = 1'b0; valid = 3'b010; set_ch(1, 32'h22);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_stall_ready", r_ready, 3'b000);
            step();
            chk("bp_stall_data", r_data, 32'h11);
            chk("bp_stall_grant", r_grant, 0);
            chk("bp_stall_valid", r_valid, 1);
        end
        ready = 1'b1;
        #1;
        chk("bp_release_ready", r_ready, 3'b010);
        step();
        chk("bp_release_data", r_data, 32'h22);
        chk("bp_release_grant", r_grant, 1);
        ready = 1'b0; set_ch(1, 32'h33);
        #1;
        chk("bp_one_cycle_ready", r_ready, 3'b000);
        step();
        chk("bp_hold_22", r_data, 32'h22);
        ready = 1'b1;
        step();
        chk("bp_load_33", r_data, 32'h33);
        valid = 3'b000;
        step();
        chk("bp_drain", r_valid, 0);

        // Wrap and sparse requests, pointer first moved to 1
        valid = 3'b001;
        step();
        chk("wrap_setup_grant", r_grant, 0);
        valid = 3'b000;
        step();
        valid = 3'b101;
        step();
        chk("wrap_grant_a", r_grant, 2);
        step();
        chk("wrap_grant_b", r_grant, 0);
        valid = 3'b000;
        step();
        step();
        chk("wrap_idle_valid", r_valid, 0);
        valid = 3'b101;
        step();
        chk("wrap_grant_c", r_grant, 2);
        valid = 3'b000;
        step();

`ifdef ARB_MUX_LOCK_EN
        // Packet lock: pointer placed at 1, then a 3-beat packet from channel 1
        valid = 3'b001;
        step();
        valid = 3'b000;
        step();
        valid = 3'b111; last = 3'b000;
        step();
        chk("lock_beat1_grant", r_grant, 1);
        chk("lock_beat1_last", r_last, 0);
        step();
        chk("lock_beat2_grant", r_grant, 1);
        chk("lock_beat2_last", r_last, 0);
        last = 3'b010;
        step();
        chk("lock_beat3_grant", r_grant, 1);
        chk("lock_beat3_last", r_last, 1);
        last = 3'b000;
        step();
        chk("lock_after_grant", r_grant, 2);
        chk("lock_after_last", r_last, 0);
        valid = 3'b000;
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
